// File: rtl/rom_stream_reader_pkg.sv
// rtl/rom_stream_reader_pkg.sv - shared types and constants for the ROM stream reader
package rom_stream_reader_pkg;

  // Default widths shared with the attached memory.
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  // Output buffering: at most this many words buffered plus in flight.
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

endpackage

// File: rtl/rom_stream_reader_stream_fifo2.sv
// rtl/rom_stream_reader_stream_fifo2.sv - two-entry synchronous FIFO with occupancy count
module stream_fifo2
  import rom_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic                  push_ok;
  logic                  pop_ok;

  // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
  assign pop_ok  = pop_i & (count_q != 2'd0);
  assign push_ok = push_i & ((count_q != 2'd2) | pop_ok);

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - walks a memory address range and streams the returned words
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  // Words buffered or in flight after this cycle's pop; pop implies count >= 1.
  assign occupancy = {1'b0, fifo_count} + {2'b00, pending_q} - {2'b00, pop};

  assign busy     = (state_q == FETCH);
  assign done     = done_q;
  assign mem_addr = addr_cnt_q;
  assign out_last = out_valid & (out_left_q == LEN_WIDTH'(1));

  // Captured memory words wait here until the consumer takes them.
  stream_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (pending_q),
    .push_data_i (mem_data),
    .pop_i       (pop),
    .head_o      (out_data),
    .count_o     (fifo_count)
  );

  // Next-state logic: accept start, issue reads under the in-flight limit, count pops.
  always_comb begin
    state_d      = state_q;
    addr_cnt_d   = addr_cnt_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    pending_d    = 1'b0;
    done_d       = 1'b0;
    issue        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d      = FETCH;
            addr_cnt_d   = base_addr;
            issue_left_d = length;
            out_left_d   = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        issue = (issue_left_q != '0) && (occupancy < 3'd2);
        if (issue) begin
          addr_cnt_d   = addr_cnt_q + ADDR_WIDTH'(1);
          issue_left_d = issue_left_q - LEN_WIDTH'(1);
          pending_d    = 1'b1;
        end
        if (pop && (out_left_q != '0)) begin
          out_left_d = out_left_q - LEN_WIDTH'(1);
          if (out_left_q == LEN_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the one-cycle read-pending flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_cnt_q   <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_cnt_q   <= addr_cnt_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - directed self-checking bench for rom_stream_reader
module tb_rom_stream_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  logic [15:0] mem [0:65535];

  int          checks;
  int          errors;
  int          n_beats;
  int          done_at;
  logic [15:0] cap_data [0:7];
  logic        cap_last [0:7];
  logic [15:0] addr_hist [0:31];
  logic        valid_any;

  rom_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory, one cycle of latency, no read enable.
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] b, input logic [16:0] l);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Records beats, mem_addr history and the cycle of the done pulse, bounded by budget.
  task automatic collect(input int budget);
    n_beats = 0;
    done_at = -1;
    for (int c = 0; c < budget; c++) begin
      addr_hist[c] = mem_addr;
      if (out_valid && out_ready) begin
        if (n_beats < 8) begin
          cap_data[n_beats] = out_data;
          cap_last[n_beats] = out_last;
        end
        n_beats++;
      end
      if (done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_seq(input string tag, input int n,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] exp_d [0:3];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    check({tag, "_nbeats"}, n_beats, n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), {16'h0, cap_data[i]}, {16'h0, exp_d[i]});
      check($sformatf("%s_last%0d", tag, i), {31'h0, cap_last[i]}, (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hA0A0; mem[16'h0011] = 16'hA1A1;
    mem[16'h0012] = 16'hA2A2; mem[16'h0013] = 16'hA3A3;
    mem[16'hFFFE] = 16'hB0B0; mem[16'hFFFF] = 16'hB1B1;
    mem[16'h0000] = 16'hB2B2; mem[16'h0001] = 16'hB3B3;
    mem[16'h0020] = 16'hC0C0;
    mem[16'h0040] = 16'hD0D0; mem[16'h0041] = 16'hD1D1;

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", out_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic: four beats back to back, done the cycle after the last.
    do_start(16'h0010, 17'd4);
    check("basic_busy", busy, 1);
    check("basic_novalid_c0", out_valid, 0);
    check("basic_addr_c0", mem_addr, 16'h0010);
    collect(20);
    check("basic_done_at", done_at, 6);
    check_seq("basic", 4, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3);
    check("basic_busy_fall", busy, 0);
    check("basic_valid_end", out_valid, 0);
    @(negedge clk);
    check("basic_done_single", done, 0);

    // Backpressure: head holds and at most two reads run ahead.
    out_ready = 1'b0;
    do_start(16'h0010, 17'd4);
    @(negedge clk);
    @(negedge clk);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 16'hA0A0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, 16'hA0A0);
      check("bp_hold_last", out_last, 0);
    end
    check("bp_addr_limit", mem_addr, 16'h0012);
    out_ready = 1'b1;
    collect(20);
    check("bp_done_at", done_at, 4);
    check_seq("bp", 4, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3);

    // Address wrap across the top of memory.
    do_start(16'hFFFE, 17'd4);
    collect(20);
    check("wrap_addr0", addr_hist[0], 16'hFFFE);
    check("wrap_addr1", addr_hist[1], 16'hFFFF);
    check("wrap_addr2", addr_hist[2], 16'h0000);
    check("wrap_addr3", addr_hist[3], 16'h0001);
    check("wrap_done_at", done_at, 6);
    check_seq("wrap", 4, 16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3);

    // Zero length: immediate done, no stream activity.
    do_start(16'h0050, 17'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    valid_any = out_valid;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid_any = valid_any | out_valid;
    end
    check("len0_novalid", valid_any, 0);
    check("len0_done_single", done, 0);

    // Single word carries out_last.
    do_start(16'h0020, 17'd1);
    collect(20);
    check("len1_done_at", done_at, 3);
    check_seq("len1", 1, 16'hC0C0, 16'h0, 16'h0, 16'h0);

    // A second start while busy is ignored.
    do_start(16'h0010, 17'd4);
    start     = 1'b1;
    base_addr = 16'h0040;
    length    = 17'd2;
    @(negedge clk);
    start     = 1'b0;
    collect(20);
    check("busy_start_done_at", done_at, 5);
    check_seq("busy_start", 4, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3);

    // Asynchronous reset mid-transfer, then a fresh transfer.
    do_start(16'h0010, 17'd4);
    @(negedge clk);
    @(negedge clk);
    check("mid_valid_pre", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_start(16'h0040, 17'd2);
    collect(20);
    check("after_rst_done_at", done_at, 4);
    check_seq("after_rst", 2, 16'hD0D0, 16'hD1D1, 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
